// File: rtl/uart_frame_sender_if.sv
// uart_frame_sender_if: request, result-buffer and UART TX handshake signals
// master is the frame sender side, slave is its environment
interface uart_frame_sender_if #(
   parameter int ADDR_W = 4
);
   logic              i_send;
   logic              o_busy;
   logic              o_frame_done;
   logic              o_error;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr;
   logic [15:0]       i_rd_data;
   logic              o_tx_start;
   logic [7:0]        o_tx_byte;
   logic              i_tx_busy;
   logic              i_tx_done;

   modport master (
      input  i_send, i_rd_data, i_tx_busy, i_tx_done,
      output o_busy, o_frame_done, o_error, o_rd_en, o_rd_addr, o_tx_start, o_tx_byte
   );

   modport slave (
      output i_send, i_rd_data, i_tx_busy, i_tx_done,
      input  o_busy, o_frame_done, o_error, o_rd_en, o_rd_addr, o_tx_start, o_tx_byte
   );
endinterface

// File: rtl/uart_frame_sender.sv
// uart_frame_sender: ships header, count, N_WORDS 16-bit words (MSB first) and
// an XOR checksum over a UART transmitter, one byte per start/done handshake
module uart_frame_sender #(
   parameter int         N_WORDS = 16,
   parameter int         ADDR_W  = 4,
   parameter logic [7:0] HEADER  = 8'hA5,
   parameter int         TIMEOUT = 65535
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   uart_frame_sender_if.master bus
);
   localparam int             KW      = 9;
   localparam logic [KW-1:0]  LAST_K  = KW'(2 * N_WORDS + 2);
   localparam logic [7:0]     COUNT   = 8'(N_WORDS);
   localparam logic [15:0]    TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, LATCH, SEND, WAIT} state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d, k_inc, sel_k;
   logic [15:0]       cnt_q, cnt_d, word_q, word_d, cur_word;
   logic [7:0]        cks_q, cks_d, byte_q, byte_d, tx_val;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              rd_en_q, rd_en_d, start_q, start_d, try_start;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // k_q is the byte being sent; from WAIT the candidate is the following byte
   assign k_inc    = k_q + KW'(1);
   assign sel_k    = (state_q == WAIT) ? k_inc : (state_q == IDLE) ? '0 : k_q;
   assign cur_word = (state_q == LATCH) ? bus.i_rd_data : word_q;
   assign tx_val   = (sel_k == '0) ? HEADER :
                     (sel_k == KW'(1)) ? COUNT :
                     (sel_k == LAST_K) ? cks_q :
                     sel_k[0] ? cur_word[7:0] : cur_word[15:8];

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      cks_d     = cks_q;
      byte_d    = byte_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      start_d   = 1'b0;
      try_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_send) begin
               busy_d    = 1'b1;
               k_d       = '0;
               cks_d     = 8'h00;
               try_start = 1'b1;
            end
         end
         LOAD: state_d = LATCH;
         LATCH: begin
            word_d    = bus.i_rd_data;
            try_start = 1'b1;
         end
         SEND: try_start = 1'b1;
         WAIT: begin
            if (bus.i_tx_done) begin
               k_d = k_inc;
               if (k_q == LAST_K) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (k_q[0] && k_inc != LAST_K) begin
                  state_d = LOAD;
                  rd_en_d = 1'b1;
                  addr_d  = ADDR_W'((k_q - KW'(1)) >> 1);
               end else begin
                  try_start = 1'b1;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (try_start) begin
         state_d = SEND;
         if (!bus.i_tx_busy) begin
            state_d = WAIT;
            start_d = 1'b1;
            byte_d  = tx_val;
            cnt_d   = 16'd0;
            cks_d   = cks_d ^ ((sel_k == '0 || sel_k == LAST_K) ? 8'h00 : tx_val);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         cks_q   <= '0;
         byte_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         cks_q   <= cks_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         start_q <= start_d;
      end
   end

   assign bus.o_busy       = busy_q;
   assign bus.o_frame_done = done_q;
   assign bus.o_error      = err_q;
   assign bus.o_rd_en      = rd_en_q;
   assign bus.o_rd_addr    = addr_q;
   assign bus.o_tx_start   = start_q;
   assign bus.o_tx_byte    = byte_q;
endmodule
